chunk_add_seq: RTL and testbench



---
 rtl/chunk_add_pkg.sv | 16 +
 rtl/adder.sv | 16 +
 rtl/chunk_add_seq.sv | 112 +++++++++++
 tb/tb_chunk_add_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/chunk_add_pkg.sv
// Shared types and constants for the chunked sequential adder.
package chunk_add_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chunk_add_state_t;

  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/adder.sv
// 3-bit ripple slice shared by the sequencer; count is the slice carry-out.
module adder (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] sum,
  output logic       count
);

  logic [3:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {3'b000, cin};
  assign sum     = total_s[2:0];
  assign count   = total_s[3];

endmodule

// File: rtl/chunk_add_seq.sv
// Adds two WIDTH-bit operands one 3-bit chunk per clock through a single
// shared adder slice, then pulses done with the full sum and carry-out.
module chunk_add_seq
  import chunk_add_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CHUNKS = WIDTH / SLICE_W;
  localparam int IDX_W  = idx_width(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  chunk_add_state_t   state_r, next_state_s;
  logic [WIDTH-1:0]   a_r, b_r, sum_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r, cout_r, busy_r, done_r;
  logic [SLICE_W-1:0] a_chunk_s, b_chunk_s, slice_sum_s;
  logic               slice_cout_s, accept_s, last_s;

  assign accept_s = start && (state_r != RUN);
  assign last_s   = (idx_r == LAST_IDX);

  // Chunk select: one-hot AND-OR mux over the latched operands
  always_comb begin
    a_chunk_s = {SLICE_W{1'b0}};
    b_chunk_s = {SLICE_W{1'b0}};
    for (int i = 0; i < CHUNKS; i++) begin
      a_chunk_s = a_chunk_s | (a_r[i*SLICE_W +: SLICE_W] & {SLICE_W{idx_r == IDX_W'(i)}});
      b_chunk_s = b_chunk_s | (b_r[i*SLICE_W +: SLICE_W] & {SLICE_W{idx_r == IDX_W'(i)}});
    end
  end

  adder u_slice (
    .a     (a_chunk_s),
    .b     (b_chunk_s),
    .cin   (carry_r),
    .sum   (slice_sum_s),
    .count (slice_cout_s)
  );

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = RUN;
        else       next_state_s = IDLE;
      end
      RUN: begin
        if (last_s) next_state_s = DONE;
        else        next_state_s = RUN;
      end
      DONE: begin
        if (start) next_state_s = RUN;
        else       next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, operand latch and progressive chunk write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == RUN);
      done_r  <= (next_state_s == DONE);
      if (accept_s) begin
        a_r     <= a;
        b_r     <= b;
        carry_r <= cin;
        idx_r   <= {IDX_W{1'b0}};
        sum_r   <= {WIDTH{1'b0}};
        cout_r  <= 1'b0;
      end else if (state_r == RUN) begin
        for (int i = 0; i < CHUNKS; i++) begin
          if (idx_r == IDX_W'(i)) sum_r[i*SLICE_W +: SLICE_W] <= slice_sum_s;
        end
        carry_r <= slice_cout_s;
        // The index parks on the last chunk rather than wrapping
        if (last_s) cout_r <= slice_cout_s;
        else        idx_r  <= idx_r + IDX_W'(1'b1);
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_chunk_add_seq.sv
// Scoreboard bench for chunk_add_seq: a 12-bit and a 3-bit instance.
module tb_chunk_add_seq;

  logic        clk = 1'b0;
  logic        reset, start, cin;
  logic [11:0] a, b, sum;
  logic        busy, done, cout;
  logic        start3, cin3;
  logic [2:0]  a3, b3, sum3;
  logic        busy3, done3, cout3;

  logic [12:0] q12[$];
  logic [3:0]  q3[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chunk_add_seq #(.WIDTH(12)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  chunk_add_seq #(.WIDTH(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  // Pulse start for one edge and push the reference result
  task automatic issue(input logic [11:0] ia, input logic [11:0] ib, input logic ic, input bit push);
    @(posedge clk); #1;
    start = 1'b1; a = ia; b = ib; cin = ic;
    if (push) q12.push_back({1'b0, ia} + {1'b0, ib} + {12'd0, ic});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called just after the accept edge; k = edges until done seen (0 = timeout)
  task automatic wait_done12(output int k, output int busy_cnt);
    k = 0; busy_cnt = 0;
    if (busy) busy_cnt++;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin k = i; break; end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic check_pop12(input string name);
    logic [12:0] exp;
    n_cmp++;
    if (q12.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, got %h", name, {cout, sum});
    end else begin
      exp = q12.pop_front();
      if ({cout, sum} !== exp) begin
        n_bad++;
        $display("FAIL %s: got cout/sum %h, expected %h", name, {cout, sum}, exp);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_cmp++;
    if ({busy, done, cout, sum} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset12: got busy/done/cout/sum %h, expected 0", {busy, done, cout, sum});
    end
    n_cmp++;
    if ({busy3, done3, cout3, sum3} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset3: got %h, expected 0", {busy3, done3, cout3, sum3});
    end
  endtask

  task automatic test_carry_chain;
    int k, bc;
    issue(12'hFFF, 12'h001, 1'b0, 1'b1);
    wait_done12(k, bc);
    n_cmp++;
    if (k !== 4) begin n_bad++; $display("FAIL carry_latency: got %0d, expected 4", k); end
    n_cmp++;
    if (bc !== 4) begin n_bad++; $display("FAIL carry_busy: got %0d cycles, expected 4", bc); end
    check_pop12("carry_result");
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL carry_pulse: done got %b, expected 0", done); end
  endtask

  task automatic test_hold;
    int k, bc;
    issue(12'h123, 12'h456, 1'b1, 1'b1);
    wait_done12(k, bc);
    check_pop12("hold_result");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({done, cout, sum} !== {1'b0, 1'b0, 12'h57A}) begin
        n_bad++;
        $display("FAIL hold_%0d: got done/cout/sum %h, expected 057A", i, {done, cout, sum});
      end
    end
  endtask

  task automatic test_ignore_busy;
    int k, bc, extra;
    issue(12'h001, 12'h001, 1'b0, 1'b1);
    #1 start = 1'b1; a = 12'hFFF; b = 12'hFFF;
    @(posedge clk); #1 start = 1'b0;
    wait_done12(k, bc);
    n_cmp++;
    if (k !== 3) begin n_bad++; $display("FAIL ignore_latency: got %0d, expected 3", k); end
    check_pop12("ignore_result");
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL ignore_extra_done: got %0d, expected 0", extra); end
  endtask

  task automatic test_abort;
    int k, bc, seen;
    issue(12'hFFF, 12'hFFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_cmp++;
    if ({busy, done, cout, sum} !== 15'd0) begin
      n_bad++;
      $display("FAIL abort_state: got busy/done/cout/sum %h, expected 0", {busy, done, cout, sum});
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL abort_done: got %0d, expected 0", seen); end
    issue(12'h00A, 12'h005, 1'b0, 1'b1);
    wait_done12(k, bc);
    check_pop12("abort_fresh");
  endtask

  task automatic test_back_to_back;
    int k, bc;
    issue(12'h800, 12'h800, 1'b0, 1'b1);
    wait_done12(k, bc);
    check_pop12("b2b_first");
    start = 1'b1; a = 12'h7FF; b = 12'h000; cin = 1'b1;
    q12.push_back(13'h0800);
    @(posedge clk); #1 start = 1'b0;
    wait_done12(k, bc);
    n_cmp++;
    if (k + 1 !== 5) begin n_bad++; $display("FAIL b2b_spacing: got %0d, expected 5", k + 1); end
    check_pop12("b2b_second");
  endtask

  task automatic test_random;
    int k, bc;
    for (int i = 0; i < 6; i++) begin
      issue(12'($urandom), 12'($urandom), 1'($urandom), 1'b1);
      wait_done12(k, bc);
      check_pop12("random");
    end
  endtask

  task automatic test_width3;
    int k;
    @(posedge clk); #1;
    start3 = 1'b1; a3 = 3'h7; b3 = 3'h7; cin3 = 1'b1;
    q3.push_back({1'b0, 3'h7} + {1'b0, 3'h7} + 4'd1);
    @(posedge clk); #1 start3 = 1'b0;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done3) begin k = i; break; end
    end
    n_cmp++;
    if (k !== 1) begin n_bad++; $display("FAIL w3_latency: got %0d, expected 1", k); end
    n_cmp++;
    if (q3.size() == 0) begin
      n_bad++; $display("FAIL w3_result: scoreboard empty");
    end else if ({cout3, sum3} !== q3[0]) begin
      n_bad++; $display("FAIL w3_result: got %h, expected %h", {cout3, sum3}, q3[0]);
    end
    if (q3.size() != 0) void'(q3.pop_front());
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_hold();
    test_ignore_busy();
    test_abort();
    test_back_to_back();
    test_random();
    test_width3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
